// File: rtl/regfile_multiport_sweep_pkg.sv
// Shared types and default sizing for the colouring-datapath register file.
package regfile_multiport_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } sweep_state_e;

  localparam int COLOR_W     = 8;
  localparam int COLOR_DEPTH = 16;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Clear-sweep controller: walks a pointer over every entry and muxes the
// sweep's zero write against the user write port.
module regfile_sweep_ctrl
  import regfile_multiport_sweep_pkg::*;
#(
  parameter  int W     = COLOR_W,
  parameter  int DEPTH = COLOR_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          clr_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [W-1:0]  mem_wdata,
  output logic          in_idle,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          wr_drop
);

  sweep_state_e  state;
  logic [AW-1:0] ptr;

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values.
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop  <= we && (state != ST_IDLE);
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_SWEEP;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (ptr == AW'(DEPTH - 1)) begin
            state    <= ST_DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned.
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    in_idle   = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_we  = we;
        in_idle = 1'b1;
      end
      ST_SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_multiport_sweep.sv
// Register file with one write port, NRD combinational read ports, optional
// write bypass, optional hard-zero entry 0, and a hardware clear sweep.
module regfile_multiport_sweep
  import regfile_multiport_sweep_pkg::*;
#(
  parameter  int W       = COLOR_W,
  parameter  int DEPTH   = COLOR_DEPTH,
  parameter  int NRD     = 2,
  parameter  bit BYPASS  = 1'b0,
  parameter  bit ZERO_R0 = 1'b0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [W-1:0]      wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*W-1:0]  rdata,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop
);

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;
  logic          in_idle;
  logic [W-1:0]  mem [DEPTH];

  regfile_sweep_ctrl #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .clr_req   (clr_req),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .in_idle   (in_idle),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .wr_drop   (wr_drop)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (ZERO_R0 && i == 0) begin : g_hard_zero
      assign mem[i] = '0;
    end else begin : g_flop
      logic [W-1:0] entry_q;
      // NOTE: entries are plain flops, so reset clears them; a RAM macro could not do this.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          entry_q <= '0;
        end else if (mem_we && mem_waddr == AW'(i)) begin
          entry_q <= mem_wdata;
        end
      end
      assign mem[i] = entry_q;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_read
    logic [AW-1:0] ra;
    logic [W-1:0]  rd;
    assign ra = raddr[k*AW +: AW];

    // Hard-zero takes priority over bypass.
    always_comb begin
      rd = mem[ra];
      if (BYPASS && in_idle && we && (waddr == ra)) begin
        rd = wdata;
      end
      if (ZERO_R0 && (ra == '0)) begin
        rd = '0;
      end
    end

    assign rdata[k*W +: W] = rd;
  end

endmodule

// File: tb/tb_regfile_multiport_sweep.sv
// Bench: three register-file variants on shared control, checked per cycle
// against an array-based model plus a directed vector table.
module tb_regfile_multiport_sweep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [3:0]  waddr;
  logic [7:0]  wdata;
  logic        clr_req;
  logic [7:0]  raddr_ab;
  logic [11:0] raddr_c;
  logic [15:0] rdata_a, rdata_b;
  logic [23:0] rdata_c;
  logic        busy_a, done_a, drop_a;
  logic        busy_b, done_b, drop_b;
  logic        busy_c, done_c, drop_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_multiport_sweep #(.W(8), .DEPTH(16), .NRD(2), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_ab), .rdata(rdata_a), .clr_req(clr_req),
    .clr_busy(busy_a), .clr_done(done_a), .wr_drop(drop_a));

  regfile_multiport_sweep #(.W(8), .DEPTH(16), .NRD(2), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_ab), .rdata(rdata_b), .clr_req(clr_req),
    .clr_busy(busy_b), .clr_done(done_b), .wr_drop(drop_b));

  regfile_multiport_sweep #(.W(8), .DEPTH(16), .NRD(3), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_c), .rdata(rdata_c), .clr_req(clr_req),
    .clr_busy(busy_c), .clr_done(done_c), .wr_drop(drop_c));

  // Reference model: contents array plus a sweep phase
  // (0 = idle, 1..16 = zeroing entry phase-1, 17 = done).
  logic [7:0] m_mem [16];
  int         m_phase = 0;
  logic       m_drop  = 1'b0;

  task automatic model_edge();
    if (!rst_n) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_phase = 0;
      m_drop  = 1'b0;
    end else begin
      m_drop = we && (m_phase != 0);
      if (m_phase == 0) begin
        if (we) m_mem[waddr] = wdata;
        if (clr_req) m_phase = 1;
      end else if (m_phase <= 16) begin
        m_mem[m_phase - 1] = 8'h00;
        m_phase++;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [3:0] a, input bit byp, input bit zr0);
    if (zr0 && a == 4'd0) return 8'h00;
    if (byp && m_phase == 0 && we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic e_busy, e_done;
    e_busy = (m_phase >= 1 && m_phase <= 16);
    e_done = (m_phase == 17);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s a_rd%0d", tag, k), rdata_a[k*8 +: 8], exp_rd(raddr_ab[k*4 +: 4], 1'b0, 1'b0));
      check($sformatf("%s b_rd%0d", tag, k), rdata_b[k*8 +: 8], exp_rd(raddr_ab[k*4 +: 4], 1'b1, 1'b0));
    end
    for (int k = 0; k < 3; k++)
      check($sformatf("%s c_rd%0d", tag, k), rdata_c[k*8 +: 8], exp_rd(raddr_c[k*4 +: 4], 1'b0, 1'b1));
    check({tag, " busy"}, {busy_a, busy_b, busy_c}, {3{e_busy}});
    check({tag, " done"}, {done_a, done_b, done_c}, {3{e_done}});
    check({tag, " drop"}, {drop_a, drop_b, drop_c}, {3{m_drop}});
  endtask

  task automatic rand_raddr();
    raddr_ab = 8'($urandom);
    raddr_c  = 12'($urandom);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; waddr = 4'(i); wdata = 8'(8'h10 + i);
      rand_raddr();
      #1 check_all("fill");
      step();
    end
    we = 1'b0;
  endtask

  typedef struct {
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] ra0, ra1;
    logic [7:0] ea0, ea1, eb0;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt;
    logic prev_busy;

    vecs[0] = '{we:1'b1, waddr:4'd3,  wdata:8'hA5, ra0:4'd7, ra1:4'd3,  ea0:8'h00, ea1:8'h00, eb0:8'h00};
    vecs[1] = '{we:1'b1, waddr:4'd15, wdata:8'h3C, ra0:4'd3, ra1:4'd15, ea0:8'hA5, ea1:8'h00, eb0:8'hA5};
    vecs[2] = '{we:1'b0, waddr:4'd0,  wdata:8'h00, ra0:4'd3, ra1:4'd15, ea0:8'hA5, ea1:8'h3C, eb0:8'hA5};
    vecs[3] = '{we:1'b0, waddr:4'd0,  wdata:8'h00, ra0:4'd7, ra1:4'd7,  ea0:8'h00, ea1:8'h00, eb0:8'h00};
    vecs[4] = '{we:1'b1, waddr:4'd5,  wdata:8'h77, ra0:4'd5, ra1:4'd3,  ea0:8'h00, ea1:8'hA5, eb0:8'h77};
    vecs[5] = '{we:1'b0, waddr:4'd0,  wdata:8'h00, ra0:4'd5, ra1:4'd5,  ea0:8'h77, ea1:8'h77, eb0:8'h77};

    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0;
    raddr_ab = '0; raddr_c = '0;
    step(); step();
    rst_n = 1'b1;
    #1 check_all("reset");
    check("reset busy_a", busy_a, 1'b0);
    check("reset rd_a0", rdata_a[7:0], 8'h00);

    // Basic write/read and same-cycle bypass.
    foreach (vecs[i]) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr_ab = {vecs[i].ra1, vecs[i].ra0};
      raddr_c  = {vecs[i].ra0, vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d a_rd0", i), rdata_a[7:0],  vecs[i].ea0);
      check($sformatf("vec%0d a_rd1", i), rdata_a[15:8], vecs[i].ea1);
      check($sformatf("vec%0d b_rd0", i), rdata_b[7:0],  vecs[i].eb0);
      check_all($sformatf("vec%0d", i));
      step();
    end
    we = 1'b0;

    // Full clear sweep with a dropped write and mid-sweep reads.
    fill_ramp();
    clr_req = 1'b1;
    #1 check_all("clr_req");
    step();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; prev_busy = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      we = 1'b0;
      rand_raddr();
      if (m_phase == 4) begin
        we = 1'b1; waddr = 4'd12; wdata = 8'hEE;
        raddr_ab = {4'd10, 4'd2};
      end
      if (m_phase == 6) raddr_ab = {4'd12, 4'd0};
      #1;
      if (m_phase == 4) begin
        check("sweep4 rd addr2", rdata_a[7:0], 8'h00);
        check("sweep4 rd addr10", rdata_a[15:8], 8'h1A);
      end
      if (m_phase == 5) check("sweep drop pulse", drop_a, 1'b1);
      if (m_phase == 6) check("sweep entry12 kept", rdata_a[15:8], 8'h1C);
      check_all("sweep");
      if (busy_a) busy_cnt++;
      if (done_a) begin
        done_cnt++;
        check("done after busy", prev_busy, 1'b1);
      end
      prev_busy = busy_a;
      step();
    end
    we = 1'b0;
    check("busy cycle count", busy_cnt, 16);
    check("done pulse count", done_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      raddr_ab = {4'(i), 4'(i)};
      #1 check($sformatf("post-sweep entry%0d", i), rdata_a[7:0], 8'h00);
    end

    // Reset in the middle of a sweep.
    fill_ramp();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 7 && m_phase != 8; i++) step();
    check("mid-sweep phase reached", busy_a, 1'b1);
    rst_n = 1'b0;
    #1 check_all("rst mid");
    step();
    rst_n = 1'b1;
    check("busy after reset", busy_a, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      raddr_ab = {4'(i), 4'(15 - i)};
      raddr_c  = 12'($urandom);
      #1 check_all("post-rst");
      if (done_a) done_cnt++;
      step();
    end
    check("no done after reset", done_cnt, 0);
    we = 1'b1; waddr = 4'd9; wdata = 8'h5A;
    step();
    we = 1'b0; raddr_ab = {4'd3, 4'd9};
    #1 check("fresh write after reset", rdata_a[7:0], 8'h5A);
    check_all("fresh");

    // Hard-zero entry 0 on the three-port variant.
    we = 1'b1; waddr = 4'd0; wdata = 8'hFF;
    raddr_c = {4'd3, 4'd9, 4'd0};
    #1 check("zr0 read during write", rdata_c[7:0], 8'h00);
    step();
    we = 1'b0;
    raddr_c = {4'd0, 4'd9, 4'd0};
    #1;
    check("zr0 port0 reads 0", rdata_c[7:0], 8'h00);
    check("zr0 port1 addr9", rdata_c[15:8], 8'h5A);
    check("zr0 port2 reads 0", rdata_c[23:16], 8'h00);
    check("zr0 no drop", drop_c, 1'b0);
    raddr_ab = {4'd0, 4'd0};
    #1 check("no-zr0 addr0 written", rdata_a[7:0], 8'hFF);
    check_all("zr0");

    // Randomized traffic, occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      we      = 1'($urandom);
      waddr   = 4'($urandom);
      wdata   = 8'($urandom);
      clr_req = ($urandom_range(0, 39) == 0);
      rand_raddr();
      #1 check_all("rand");
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
